// File: rtl/regwb_queue.sv
// regwb_queue: FIFO of pending register-file writes with a scoreboard lookup (busy_x) and optional forwarding (fwd_x, enabled by REGWB_FWD_EN).
// Latency: an entry pops on the edge after its transfer; regwr/rw/busw are registered, so the write appears the cycle after that pop edge.
// Backpressure: in_ready drops when full, flushing or in reset (never relaxed by a same-cycle pop); draining pauses while wr_stall is high.
module regwb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rw,
    input  logic [31:0]              in_data,
    input  logic                     wr_stall,
    input  logic                     flush,
    output logic                     regwr,
    output logic [4:0]               rw,
    output logic [31:0]              busw,
    input  logic [4:0]               qa,
    input  logic [4:0]               qb,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [31:0]              fwd_a,
    output logic [31:0]              fwd_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] dat;
    } ent_t;

    ent_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [AW-1:0] idx;
    logic          hit_a;
    logic          hit_b;
    logic          last_a;
    logic          last_b;
`ifdef REGWB_FWD_EN
    logic [31:0]   qdat_a;
    logic [31:0]   qdat_b;
`endif

    // Space check only; a pop in the same cycle does not free a slot early.
    assign in_ready = rst && !flush && (count < CW'(DEPTH));

    // Writes to r0 complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_rw != 5'd0);

    // Drain one entry per cycle whenever the register-file port is free.
    assign pop = rst && !flush && !wr_stall && (count != '0);

    // Entry storage; only live slots are ever read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ent_t'({in_rw, in_data});
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            regwr  <= 1'b0;
            rw     <= '0;
            busw   <= '0;
        end else if (flush) begin
            // Flush beats push and pop; rw/busw keep their last values.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            regwr  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                regwr  <= 1'b1;
                rw     <= mem[rd_ptr].rw;
                busw   <= mem[rd_ptr].dat;
            end else begin
                regwr  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scan live entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx   = '0;
`ifdef REGWB_FWD_EN
        qdat_a = '0;
        qdat_b = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (CW'(i) < count) begin
                if (mem[idx].rw == qa) begin
                    hit_a = 1'b1;
`ifdef REGWB_FWD_EN
                    qdat_a = mem[idx].dat;
`endif
                end
                if (mem[idx].rw == qb) begin
                    hit_b = 1'b1;
`ifdef REGWB_FWD_EN
                    qdat_b = mem[idx].dat;
`endif
                end
            end
        end
    end

    // The write currently on the register-file port is still in flight for readers.
    assign last_a = regwr && (rw == qa);
    assign last_b = regwr && (rw == qb);

    // r0 is never busy; anything else is busy while a queued or in-flight write targets it.
    assign busy_a = (qa != 5'd0) && (hit_a || last_a);
    assign busy_b = (qb != 5'd0) && (hit_b || last_b);

`ifdef REGWB_FWD_EN
    // Youngest queued value wins over the in-flight write.
    assign fwd_a = hit_a ? qdat_a : (last_a ? busw : 32'd0);
    assign fwd_b = hit_b ? qdat_b : (last_b ? busw : 32'd0);
`else
    // No forwarding: the datapath stalls on busy_x instead.
    assign fwd_a = 32'd0;
    assign fwd_b = 32'd0;
`endif

endmodule

// File: tb/tb_regwb_queue.sv
// tb_regwb_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_regwb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] dat;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rw;
    logic [31:0]   in_data;
    logic          wr_stall;
    logic          flush;
    logic          regwr;
    logic [4:0]    rw;
    logic [31:0]   busw;
    logic [4:0]    qa;
    logic [4:0]    qb;
    logic          busy_a;
    logic          busy_b;
    logic [31:0]   fwd_a;
    logic [31:0]   fwd_b;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    ent_t        m_q[$];
    logic        m_regwr = 1'b0;
    logic [4:0]  m_rw    = 5'd0;
    logic [31:0] m_busw  = 32'd0;

    regwb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rw    (in_rw),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .flush    (flush),
        .regwr    (regwr),
        .rw       (rw),
        .busw     (busw),
        .qa       (qa),
        .qb       (qb),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_busy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].rw == q) return 1'b1;
        return m_regwr && (m_rw == q);
    endfunction

`ifdef REGWB_FWD_EN
    function automatic logic [31:0] exp_fwd(input logic [4:0] q);
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].rw == q) return m_q[i].dat;
        end
        if (m_regwr && (m_rw == q)) return m_busw;
        return 32'd0;
    endfunction
`endif

    // One clock: compare all outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic exp_rdy;
        logic do_pop;
        logic do_push;
        ent_t h;
        @(negedge clk);
        exp_rdy = rst && !flush && (m_q.size() < DEPTH);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("count", 32'(count), 32'(m_q.size()));
        chk("regwr", {31'd0, regwr}, {31'd0, m_regwr});
        chk("rw", {27'd0, rw}, {27'd0, m_rw});
        chk("busw", busw, m_busw);
        chk("busy_a", {31'd0, busy_a}, {31'd0, exp_busy(qa)});
        chk("busy_b", {31'd0, busy_b}, {31'd0, exp_busy(qb)});
`ifdef REGWB_FWD_EN
        chk("fwd_a", fwd_a, exp_fwd(qa));
        chk("fwd_b", fwd_b, exp_fwd(qb));
`else
        chk("fwd_a", fwd_a, 32'd0);
        chk("fwd_b", fwd_b, 32'd0);
`endif
        if (!rst) begin
            m_q.delete();
            m_regwr = 1'b0;
            m_rw    = 5'd0;
            m_busw  = 32'd0;
        end else if (flush) begin
            m_q.delete();
            m_regwr = 1'b0;
        end else begin
            do_pop  = (m_q.size() > 0) && !wr_stall;
            do_push = in_valid && exp_rdy && (in_rw != 5'd0);
            if (do_pop) begin
                h       = m_q.pop_front();
                m_regwr = 1'b1;
                m_rw    = h.rw;
                m_busw  = h.dat;
            end else begin
                m_regwr = 1'b0;
            end
            if (do_push) m_q.push_back(ent_t'({in_rw, in_data}));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_rw    = r;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rw = 5'd0; in_data = 32'd0;
        wr_stall = 1'b0; flush = 1'b0; qa = 5'd0; qb = 5'd0;

        // Reset
        @(posedge clk);
        #1;
        cycle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_regwr", {31'd0, regwr}, 32'd0);
        chk("rst_rw", {27'd0, rw}, 32'd0);
        chk("rst_busw", busw, 32'd0);
        rst = 1'b1;
        cycle();

        // Single write latency
        push(5'd5, 32'h1111_1111);
        chk("lat_e1_regwr", {31'd0, regwr}, 32'd0);
        chk("lat_e1_count", 32'(count), 32'd1);
        cycle();
        chk("lat_regwr", {31'd0, regwr}, 32'd1);
        chk("lat_rw", {27'd0, rw}, 32'd5);
        chk("lat_busw", busw, 32'h1111_1111);
        chk("lat_count", 32'(count), 32'd0);
        cycle();
        chk("lat_pulse_end", {31'd0, regwr}, 32'd0);

        // Fill while stalled, then drain in order
        wr_stall = 1'b1;
        for (int k = 1; k <= 4; k++) push(5'(k), 32'h100 + 32'(k));
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        wr_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("drain_regwr", {31'd0, regwr}, 32'd1);
            chk("drain_rw", {27'd0, rw}, 32'(k));
        end
        cycle();
        chk("drain_done", {31'd0, regwr}, 32'd0);

        // Full queue: offered push refused while a pop happens, then push+pop
        wr_stall = 1'b1;
        for (int k = 8; k <= 11; k++) push(5'(k), 32'h200 + 32'(k));
        wr_stall = 1'b0;
        in_valid = 1'b1; in_rw = 5'd12; in_data = 32'h20C;
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("full_pop_count", 32'(count), 32'd3);
        in_rw = 5'd13; in_data = 32'h20D;
        cycle();
        chk("pushpop_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        repeat (5) cycle();

        // r0 writes are swallowed
        in_valid = 1'b1; in_rw = 5'd0; in_data = 32'hDEAD_BEEF;
        chk("r0_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        in_valid = 1'b0;
        chk("r0_count", 32'(count), 32'd0);
        cycle();
        chk("r0_regwr", {31'd0, regwr}, 32'd0);

        // Hazard lookup with two writes to the same register
        wr_stall = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        qa = 5'd7; qb = 5'd3;
        #1;
        chk("haz_busy_a", {31'd0, busy_a}, 32'd1);
        chk("haz_busy_b", {31'd0, busy_b}, 32'd0);
`ifdef REGWB_FWD_EN
        chk("haz_fwd_a", fwd_a, 32'hB);
`else
        chk("haz_fwd_a", fwd_a, 32'd0);
`endif
        qa = 5'd0;
        #1;
        chk("haz_q0", {31'd0, busy_a}, 32'd0);

        // Flush with three pending entries
        push(5'd9, 32'hC);
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_regwr", {31'd0, regwr}, 32'd0);
        wr_stall = 1'b0;
        repeat (4) begin
            cycle();
            chk("post_flush_regwr", {31'd0, regwr}, 32'd0);
        end

        // Reset mid-drain
        wr_stall = 1'b1;
        for (int k = 20; k <= 22; k++) push(5'(k), 32'h300 + 32'(k));
        wr_stall = 1'b0;
        cycle();
        chk("mid_regwr", {31'd0, regwr}, 32'd1);
        rst = 1'b0;
        cycle();
        chk("mid_rst_regwr", {31'd0, regwr}, 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_rw", {27'd0, rw}, 32'd0);
        chk("mid_rst_busw", busw, 32'd0);
        rst = 1'b1;
        repeat (4) begin
            cycle();
            chk("post_rst_regwr", {31'd0, regwr}, 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) >= 2);
            flush    = ($urandom_range(0, 99) < 3);
            wr_stall = ($urandom_range(0, 99) < 35);
            in_valid = ($urandom_range(0, 99) < 60);
            in_rw    = 5'($urandom_range(0, 12));
            in_data  = $urandom;
            qa       = 5'($urandom_range(0, 12));
            qb       = 5'($urandom_range(0, 12));
            cycle();
        end
        rst = 1'b1; flush = 1'b0; wr_stall = 1'b0; in_valid = 1'b0;
        repeat (6) cycle();
        chk("end_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
